// File: rtl/riscv_pkg.sv
// Shared encodings for the core sequencer: opcodes, FSM states, instruction classes,
// write-back mux selects and trap causes.
package riscv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    CLS_NONE,
    CLS_OP,
    CLS_OP_IMM,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JAL,
    CLS_JALR,
    CLS_LUI,
    CLS_AUIPC
  } cls_t;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  localparam logic [1:0] TC_NONE    = 2'd0;
  localparam logic [1:0] TC_ILLEGAL = 2'd1;
  localparam logic [1:0] TC_TIMEOUT = 2'd2;

  // Register-file write source for a class; classes that never write return WB_ALU.
  function automatic logic [1:0] wb_sel_of(input cls_t c);
    case (c)
      CLS_LOAD:          return WB_MEM;
      CLS_JAL, CLS_JALR: return WB_PC4;
      CLS_LUI:           return WB_IMM;
      default:           return WB_ALU;
    endcase
  endfunction

endpackage

// File: rtl/core_seq_class.sv
// Opcode to instruction-class decode, purely combinational (zero latency).
// Unknown opcodes report illegal with class NONE.
module core_seq_class
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  output cls_t       cls,
  output logic       illegal
);

  always_comb begin
    cls     = CLS_NONE;
    illegal = 1'b0;
    case (opcode)
      OPC_OP:     cls = CLS_OP;
      OPC_OP_IMM: cls = CLS_OP_IMM;
      OPC_LOAD:   cls = CLS_LOAD;
      OPC_STORE:  cls = CLS_STORE;
      OPC_BRANCH: cls = CLS_BRANCH;
      OPC_JAL:    cls = CLS_JAL;
      OPC_JALR:   cls = CLS_JALR;
      OPC_LUI:    cls = CLS_LUI;
      OPC_AUIPC:  cls = CLS_AUIPC;
      default:    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/core_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer driving all datapath enables and selects.
// Stalls in FETCH on imem_rdy, EXEC on alu_valid, MEM on dmem_ack (bounded by TIMEOUT).
module core_seq_ctrl
  import riscv_pkg::*;
#(
  parameter int RET_W   = 32,
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt_req,
  input  logic             trap_clr,
  input  logic [6:0]       opcode,
  input  logic             imem_rdy,
  input  logic             alu_valid,
  input  logic             branch_taken,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             ir_ld,
  output logic             alu_start,
  output logic             ra_sel_pc,
  output logic             rb_sel_imm,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             reg_wr,
  output logic [1:0]       wb_sel,
  output logic             pc_en,
  output logic             pc_sel_branch,
  output logic             busy,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [RET_W-1:0] retired
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  cls_t             class_q, class_d;
  cls_t             dec_cls;
  logic             dec_illegal;
  logic [1:0]       cause_q, cause_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             taken_q, taken_d;
  logic             alu_go_q, alu_go_d;
  logic             ret_inc;
  logic [RET_W-1:0] retired_q;

  core_seq_class u_class (
    .opcode  (opcode),
    .cls     (dec_cls),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      class_q   <= CLS_NONE;
      cause_q   <= TC_NONE;
      to_cnt_q  <= '0;
      taken_q   <= 1'b0;
      alu_go_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q  <= state_d;
      class_q  <= class_d;
      cause_q  <= cause_d;
      to_cnt_q <= to_cnt_d;
      taken_q  <= taken_d;
      alu_go_q <= alu_go_d;
      if (ret_inc) retired_q <= retired_q + RET_W'(1);
    end
  end

  always_comb begin
    state_d       = state_q;
    class_d       = class_q;
    cause_d       = cause_q;
    to_cnt_d      = '0;
    taken_d       = taken_q;
    alu_go_d      = 1'b0;
    ret_inc       = 1'b0;
    imem_req      = 1'b0;
    ir_ld         = 1'b0;
    alu_start     = 1'b0;
    ra_sel_pc     = 1'b0;
    rb_sel_imm    = 1'b0;
    mem_rd        = 1'b0;
    mem_wr        = 1'b0;
    reg_wr        = 1'b0;
    wb_sel        = WB_ALU;
    pc_en         = 1'b0;
    pc_sel_branch = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end

      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_rdy) begin
          ir_ld   = 1'b1;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        class_d = dec_cls;
        if (dec_illegal) begin
          cause_d = TC_ILLEGAL;
          state_d = S_TRAP;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        // alu_go_q marks that the launch pulse has already been issued.
        alu_start  = !alu_go_q;
        alu_go_d   = 1'b1;
        ra_sel_pc  = (class_q == CLS_AUIPC) || (class_q == CLS_JAL) ||
                     (class_q == CLS_BRANCH);
        rb_sel_imm = (class_q != CLS_OP);
        if (class_q == CLS_LUI) begin
          state_d = S_WB;
        end else if (alu_valid) begin
          taken_d = branch_taken;
          state_d = ((class_q == CLS_LOAD) || (class_q == CLS_STORE)) ? S_MEM : S_WB;
        end
      end

      S_MEM: begin
        mem_rd = (class_q == CLS_LOAD);
        mem_wr = (class_q == CLS_STORE);
        if (dmem_ack) begin
          if (class_q == CLS_STORE) begin
            pc_en   = 1'b1;
            ret_inc = 1'b1;
            state_d = halt_req ? S_IDLE : S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (to_cnt_q == TO_LAST) begin
          // This cycle's miss brings the count to TIMEOUT.
          cause_d = TC_TIMEOUT;
          state_d = S_TRAP;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      S_WB: begin
        reg_wr        = (class_q != CLS_BRANCH);
        wb_sel        = wb_sel_of(class_q);
        pc_en         = 1'b1;
        pc_sel_branch = (class_q == CLS_JAL) || (class_q == CLS_JALR) ||
                        ((class_q == CLS_BRANCH) && taken_q);
        ret_inc       = 1'b1;
        state_d       = halt_req ? S_IDLE : S_FETCH;
      end

      S_TRAP: begin
        if (trap_clr) begin
          cause_d = TC_NONE;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy       = (state_q != S_IDLE) && (state_q != S_TRAP);
  assign trap       = (state_q == S_TRAP);
  assign trap_cause = cause_q;
  assign retired    = retired_q;

endmodule
